vote_result_uart_tx: RTL and testbench
======================================

# vote_result_uart_tx

Serial result reporter for the secure voting machine. When the tally is closed, it takes a snapshot of the final counts, winner and tie status and transmits them as a fixed six-byte UART frame (8N1, LSB first) to an external display or logging terminal. It sits downstream of the voting core's result outputs and drives a single board-level TX pin.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal minimum is 2.
- HEADER, default 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  request to send one frame; sampled on posedge clk
- count_a  in  8  final tally for candidate A
- count_b  in  8  final tally for candidate B
- count_c  in  8  final tally for candidate C
- winner  in  2  00=A, 01=B, 10=C, 11=none
- tie_flag  in  1  tie indicator from the voting core
- tx  out  1  UART serial line; idles high
- busy  out  1  high while a frame is in flight
- done  out  1  one-cycle pulse at the end of a frame

## Operation
- Frame bytes, in order:
  - B0 = HEADER
  - B1 = count_a
  - B2 = count_b
  - B3 = count_c
  - B4 = {5'b0, tie_flag, winner}
  - B5 = B0^B1^B2^B3^B4 (XOR checksum)
- Each byte is sent as one start bit (0), 8 data bits LSB first, then one stop bit (1): 10 bit times per byte, 60 bit times per frame.
- Snapshot rule: count_a/b/c, winner and tie_flag are registered on the cycle start is accepted. Input changes during the frame do not affect it. The checksum is computed from the snapshot.
- start is accepted only in IDLE. While busy, start is ignored and is not queued.
- FSM states:
  - IDLE: tx=1, busy=0. On start, take the snapshot, set byte_idx=0, go to START_BIT.
  - START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=byte[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP_BIT.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<5: byte_idx++ and go to START_BIT
    - else: go to IDLE and pulse done.
- Counters:
  - baud counter: clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary
  - bit_idx: 3 bits
  - byte_idx: 3 bits
- tx is driven directly from a flop, with no combinational glitch path.
- Unused or illegal state encodings return to IDLE with tx=1.

## Timing
- Reset values (asynchronous, take effect immediately mid-frame): tx=1, busy=0, done=0, state=IDLE, all counters 0. Any frame in progress is discarded. After reset is released, a new start is needed.
- Let edge E be the edge that samples start=1 in IDLE. At E: tx goes 0 and busy goes 1 (one-cycle latency).
- Every bit is held for exactly CLKS_PER_BIT cycles. No idle gap between bytes: the start bit of byte n+1 directly follows the stop bit of byte n.
- At edge E+60*CLKS_PER_BIT: busy falls to 0 and done is 1 for exactly one cycle. tx stays 1.
- Back-to-back: start held high during the done cycle is accepted at the next edge, so consecutive frames have zero idle bit time.
- A start pulse during busy, including in the last stop bit, has no effect.

## Test plan
1. CLKS_PER_BIT=4, a=3, b=5, c=1, winner=01, tie=0, start pulse.
   - Required: decoded bytes A5 03 05 01 01 A3
   - busy high for exactly 240 cycles
   - done pulse at E+240
2. a=4, b=4, c=2, winner=00, tie=1.
   - Required: B4=0x04, checksum 0xA3
   - each bit measured at exactly 4 cycles
3. Change count_a from 3 to 9 and pulse start again in mid-frame.
   - Required: frame still carries 03
   - second start ignored: exactly one done, no second frame
4. Assert reset halfway through byte B2.
   - Required: tx=1 and busy=0 in the same cycle
   - line stays high until a new start, which then sends a full, correct frame
5. Hold start high continuously.
   - Required: two frames with the second start bit immediately after the first frame's final stop bit
   - one done pulse per frame
6. a=b=c=255, winner=11.
   - Required: bytes A5 FF FF FF 03, checksum 0xA5^0xFF^0xFF^0xFF^0x03 = 0x59

Source files
------------

// File: rtl/vote_result_uart_tx_if.sv
// Result-reporter bus: the voting core drives the snapshot request and tally data;
// the reporter drives the serial line and its status flags.
interface vote_result_uart_tx_if;
    logic       start;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic [7:0] count_c;
    logic [1:0] winner;
    logic       tie_flag;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start, count_a, count_b, count_c, winner, tie_flag,
        input  tx, busy, done
    );

    modport slave (
        input  start, count_a, count_b, count_c, winner, tie_flag,
        output tx, busy, done
    );
endinterface

// File: rtl/vote_result_uart_tx.sv
// Snapshots the closed tally and sends it as a six-byte 8N1 UART frame:
// header, three counts, {tie, winner}, XOR checksum.
module vote_result_uart_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    vote_result_uart_tx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA      = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic [7:0] snap_a;
    logic [7:0] snap_b;
    logic [7:0] snap_c;
    logic [7:0] snap_stat;
    logic [7:0] cur_byte;
    logic       start_acc;
    logic       bit_end;

    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b1, input logic [7:0] b2,
        input logic [7:0] b3, input logic [7:0] b4
    );
        return HEADER ^ b1 ^ b2 ^ b3 ^ b4;
    endfunction

    assign start_acc = (state == IDLE) && bus.start;
    assign bit_end   = (baud_cnt == BAUD_LAST);

    // Snapshot is data only: it is meaningless until a start is accepted, so it carries no reset.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            snap_a    <= bus.count_a;
            snap_b    <= bus.count_b;
            snap_c    <= bus.count_c;
            snap_stat <= {5'b0, bus.tie_flag, bus.winner};
        end
    end

    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = snap_a;
            3'd2:    cur_byte = snap_b;
            3'd3:    cur_byte = snap_c;
            3'd4:    cur_byte = snap_stat;
            3'd5:    cur_byte = frame_checksum(snap_a, snap_b, snap_c, snap_stat);
            default: cur_byte = HEADER;
        endcase
    end

    // tx is loaded one edge ahead of each bit so the pin comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    baud_cnt <= '0;
                    if (bus.start) begin
                        state    <= START_BIT;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx < 3'd5) begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_q     <= 1'b0;
                            state    <= START_BIT;
                        end else begin
                            byte_idx <= '0;
                            tx_q     <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                end
            endcase
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_vote_result_uart_tx.sv
// Directed bench for vote_result_uart_tx at four clocks per bit; every frame byte
// and the bit-level waveform are checked against hand-computed values.
module tb_vote_result_uart_tx;

    localparam int CPB = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vote_result_uart_tx_if vif ();

    vote_result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [1:0] w, input logic t);
        vif.count_a  = a;
        vif.count_b  = b;
        vif.count_c  = c;
        vif.winner   = w;
        vif.tie_flag = t;
    endtask

    // Caller raises start beforehand; the next edge is E. Returns just after edge E+240.
    task automatic run_frame(input string name, input logic [5:0][7:0] exp,
                             input bit hold, input bit glitch);
        logic [5:0][7:0] dec;
        int   bad;
        int   n;
        logic exp_bit;
        dec = '0;
        bad = 0;
        @(posedge clk); #1;
        if (!hold) vif.start = 1'b0;
        chk({name, "_E_tx"}, 32'(vif.tx), 32'd0);
        chk({name, "_E_busy"}, 32'(vif.busy), 32'd1);
        for (int k = 0; k < 60 * CPB; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (glitch && k == 100) begin
                vif.count_a = 8'h09;
                vif.start   = 1'b1;
            end
            if (glitch && k == 101) vif.start = 1'b0;
            n = k / CPB;
            if ((n % 10) == 0)      exp_bit = 1'b0;
            else if ((n % 10) == 9) exp_bit = 1'b1;
            else                    exp_bit = exp[n / 10][(n % 10) - 1];
            if (vif.tx !== exp_bit || vif.busy !== 1'b1 || vif.done !== 1'b0) bad++;
            if ((k % CPB) == (CPB / 2) && (n % 10) >= 1 && (n % 10) <= 8)
                dec[n / 10][(n % 10) - 1] = vif.tx;
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(dec[i]), 32'(exp[i]));
        chk({name, "_wave_bad_cycles"}, 32'(bad), 32'd0);
        @(posedge clk); #1;
        chk({name, "_end_busy"}, 32'(vif.busy), 32'd0);
        chk({name, "_end_done"}, 32'(vif.done), 32'd1);
        chk({name, "_end_tx"}, 32'(vif.tx), 32'd1);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (vif.tx !== 1'b1 || vif.busy !== 1'b0 || vif.done !== 1'b0) bad++;
        end
        chk({name, "_idle_bad_cycles"}, 32'(bad), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        vif.start = 1'b0;
        set_inputs(8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
        #1;
        chk("reset_tx", 32'(vif.tx), 32'd1);
        chk("reset_busy", 32'(vif.busy), 32'd0);
        chk("reset_done", 32'(vif.done), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_check("post_reset", 5);

        // Frame 1 with a mid-frame input change and ignored start
        set_inputs(8'd3, 8'd5, 8'd1, 2'b01, 1'b0);
        vif.start = 1'b1;
        run_frame("f1", {8'hA3, 8'h01, 8'h01, 8'h05, 8'h03, 8'hA5}, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("f1_done_one_cycle", 32'(vif.done), 32'd0);
        idle_check("f1_no_second_frame", 40);

        // Frame 2: tie set, winner A
        set_inputs(8'd4, 8'd4, 8'd2, 2'b00, 1'b1);
        vif.start = 1'b1;
        run_frame("f2", {8'hA3, 8'h04, 8'h02, 8'h04, 8'h04, 8'hA5}, 1'b0, 1'b0);
        idle_check("f2_after", 4);

        // Reset asserted in the middle of byte B2
        set_inputs(8'h12, 8'h34, 8'h56, 2'b10, 1'b0);
        vif.start = 1'b1;
        @(posedge clk); #1;
        vif.start = 1'b0;
        repeat (100) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_tx", 32'(vif.tx), 32'd1);
        chk("midreset_busy", 32'(vif.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_check("midreset_line", 30);
        vif.start = 1'b1;
        run_frame("f4", {8'hD7, 8'h02, 8'h56, 8'h34, 8'h12, 8'hA5}, 1'b0, 1'b0);
        idle_check("f4_after", 4);

        // Start held high: two frames back to back
        set_inputs(8'd7, 8'd0, 8'd9, 2'b10, 1'b0);
        vif.start = 1'b1;
        run_frame("b2b_1", {8'hA9, 8'h02, 8'h09, 8'h00, 8'h07, 8'hA5}, 1'b1, 1'b0);
        run_frame("b2b_2", {8'hA9, 8'h02, 8'h09, 8'h00, 8'h07, 8'hA5}, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_done_one_cycle", 32'(vif.done), 32'd0);
        idle_check("b2b_after", 20);

        // All-ones counts, no winner
        set_inputs(8'hFF, 8'hFF, 8'hFF, 2'b11, 1'b0);
        vif.start = 1'b1;
        run_frame("f6", {8'h59, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hA5}, 1'b0, 1'b0);
        idle_check("f6_after", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
